// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
package fwd_pkg;

  // Select value meaning "take the operand from the register file"
  localparam int FWD_RF = 0;

  // Latency classes: bubbles a consumer needs before it may enter EX
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  // Width of a forward select able to name the register file plus every stage
  function automatic int sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Per-register countdown scoreboard for multi-cycle producers.
// Each counter holds the number of bubbles still owed before a consumer of
// that register may enter EX; it reports RAW and WAW hazards for the ID slot.
module fwd_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      set_en_i,
  input  logic [REG_AW-1:0]         set_reg_i,
  input  logic [LAT_W-1:0]          set_lat_i,
  input  logic                      valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_i,
  input  logic [NUM_SRC-1:0]        src_used_i,
  input  logic                      wr_en_i,
  input  logic [REG_AW-1:0]         dst_i,
  input  logic [LAT_W-1:0]          lat_i,
  output logic                      raw_o,
  output logic                      waw_o
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];

  // Next counter values: an issue write wins, otherwise count down to zero
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (set_en_i && (set_reg_i == REG_AW'(r))) begin
        cnt_d[r] = set_lat_i;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
    cnt_d[0] = '0;
  end

  // Counter array; reset clears every pending producer at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Hazard lookup: a read of a busy register, or a write that would retire
  // before an older in-flight write to the same register
  always_comb begin
    logic [REG_AW-1:0] src;
    raw_o = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src = src_i[s*REG_AW +: REG_AW];
      if (src_used_i[s] && (src != '0) && (cnt_q[src] != '0)) begin
        raw_o = 1'b1;
      end
    end
    raw_o = raw_o & valid_i;
    waw_o = valid_i & wr_en_i & (dst_i != '0) & (cnt_q[dst_i] > lat_i);
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select prediction and load/multiply hazard stall between ID and EX.
// Selects are predicted in ID from where each producer will sit next cycle and
// registered so they line up with the instruction once it reaches EX.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int MAX_LAT    = 3,
  parameter int SEL_W      = sel_w(NUM_STAGES)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]      id_src_i,
  input  logic [NUM_SRC-1:0]             id_src_used_i,
  input  logic                           id_wr_en_i,
  input  logic [REG_AW-1:0]              id_dst_i,
  input  logic [$clog2(MAX_LAT+1)-1:0]   id_lat_i,
  input  logic                           flush_i,
  input  logic                           ex_wr_en_i,
  input  logic [REG_AW-1:0]              ex_rd_i,
  input  logic [NUM_STAGES-1:0]          st_wr_en_i,
  input  logic [NUM_STAGES*REG_AW-1:0]   st_rd_i,
  output logic                           stall_o,
  output logic [NUM_SRC*SEL_W-1:0]       fwd_sel_o,
  output logic [31:0]                    stall_cnt_o
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic                     raw;
  logic                     waw;
  logic                     issue;
  logic                     sb_set_en;
  logic [NUM_SRC*SEL_W-1:0] pred_sel;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
  logic [31:0]              stall_cnt_d;
  logic [31:0]              stall_cnt_q;
  logic                     unused_oldest_stage;

  // The oldest stage's producer leaves the forwarding window next cycle,
  // so it can never be a forwarding source for the instruction in ID.
  assign unused_oldest_stage = ^{st_wr_en_i[NUM_STAGES-1],
                                 st_rd_i[(NUM_STAGES-1)*REG_AW +: REG_AW]};

  fwd_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (sb_set_en),
    .set_reg_i  (id_dst_i),
    .set_lat_i  (id_lat_i),
    .valid_i    (id_valid_i),
    .src_i      (id_src_i),
    .src_used_i (id_src_used_i),
    .wr_en_i    (id_wr_en_i),
    .dst_i      (id_dst_i),
    .lat_i      (id_lat_i),
    .raw_o      (raw),
    .waw_o      (waw)
  );

  // Stall and issue decisions; flush overrides both
  always_comb begin
    stall_o   = (raw | waw) & ~flush_i;
    issue     = id_valid_i & ~stall_o & ~flush_i;
    sb_set_en = issue & id_wr_en_i & (id_dst_i != '0);
  end

  // Predict each operand's select: scan oldest to youngest so the youngest
  // matching producer (the one currently in EX) has the final say
  always_comb begin
    logic [REG_AW-1:0] src;
    logic [SEL_W-1:0]  sel;
    pred_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src = id_src_i[s*REG_AW +: REG_AW];
      sel = SEL_W'(FWD_RF);
      if (id_src_used_i[s] && (src != '0)) begin
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
          if (st_wr_en_i[k-1] && (st_rd_i[(k-1)*REG_AW +: REG_AW] == src)) begin
            sel = SEL_W'(k + 1);
          end
        end
        if (ex_wr_en_i && (ex_rd_i == src)) begin
          sel = SEL_W'(1);
        end
      end
      pred_sel[s*SEL_W +: SEL_W] = sel;
    end
  end

  // Next register values: bubbles carry an all-RF select; stall count saturates
  always_comb begin
    fwd_sel_d   = issue ? pred_sel : '0;
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Select register travelling with the ID/EX pipeline register, plus stall counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel_o   = fwd_sel_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized checks of fwd_hazard_unit against a behavioural model.
module tb_fwd_hazard_unit;

  localparam int REG_AW     = 5;
  localparam int NUM_SRC    = 2;
  localparam int NUM_STAGES = 2;
  localparam int MAX_LAT    = 3;
  localparam int SEL_W      = $clog2(NUM_STAGES + 1);
  localparam int LAT_W      = $clog2(MAX_LAT + 1);
  localparam int NUM_REGS   = 2 ** REG_AW;

  logic                         clk_i = 1'b0;
  logic                         rst_i = 1'b0;
  logic                         id_valid_i = 1'b0;
  logic [NUM_SRC*REG_AW-1:0]    id_src_i = '0;
  logic [NUM_SRC-1:0]           id_src_used_i = '0;
  logic                         id_wr_en_i = 1'b0;
  logic [REG_AW-1:0]            id_dst_i = '0;
  logic [LAT_W-1:0]             id_lat_i = '0;
  logic                         flush_i = 1'b0;
  logic                         ex_wr_en_i = 1'b0;
  logic [REG_AW-1:0]            ex_rd_i = '0;
  logic [NUM_STAGES-1:0]        st_wr_en_i = '0;
  logic [NUM_STAGES*REG_AW-1:0] st_rd_i = '0;
  logic                         stall_o;
  logic [NUM_SRC*SEL_W-1:0]     fwd_sel_o;
  logic [31:0]                  stall_cnt_o;

  int              vectors = 0;
  int              miscompares = 0;
  int              cnt_m [NUM_REGS];
  int              sel_m [NUM_SRC];
  longint unsigned stall_cnt_m = 0;

  fwd_hazard_unit #(
    .REG_AW     (REG_AW),
    .NUM_SRC    (NUM_SRC),
    .NUM_STAGES (NUM_STAGES),
    .MAX_LAT    (MAX_LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_src_i      (id_src_i),
    .id_src_used_i (id_src_used_i),
    .id_wr_en_i    (id_wr_en_i),
    .id_dst_i      (id_dst_i),
    .id_lat_i      (id_lat_i),
    .flush_i       (flush_i),
    .ex_wr_en_i    (ex_wr_en_i),
    .ex_rd_i       (ex_rd_i),
    .st_wr_en_i    (st_wr_en_i),
    .st_rd_i       (st_rd_i),
    .stall_o       (stall_o),
    .fwd_sel_o     (fwd_sel_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Free-running clock, 10 time units per period
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int valid, input int src0, input int src1,
                               input int used, input int wr, input int dst,
                               input int lat, input int flush, input int exw,
                               input int exrd, input int stw, input int st1rd,
                               input int st2rd);
    id_valid_i    = valid[0];
    id_src_i      = {REG_AW'(src1), REG_AW'(src0)};
    id_src_used_i = NUM_SRC'(used);
    id_wr_en_i    = wr[0];
    id_dst_i      = REG_AW'(dst);
    id_lat_i      = LAT_W'(lat);
    flush_i       = flush[0];
    ex_wr_en_i    = exw[0];
    ex_rd_i       = REG_AW'(exrd);
    st_wr_en_i    = NUM_STAGES'(stw);
    st_rd_i       = {REG_AW'(st2rd), REG_AW'(st1rd)};
  endtask

  function automatic int srcOf(input int s);
    return int'(id_src_i[s*REG_AW +: REG_AW]);
  endfunction

  // Reference stall: a read of a register still owing bubbles, or a write
  // that would complete ahead of a slower older write to the same register
  function automatic bit modelStall();
    bit hazard = 1'b0;
    if (!rst_i || !id_valid_i || flush_i) return 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_src_used_i[s] && srcOf(s) != 0 && cnt_m[srcOf(s)] > 0) hazard = 1'b1;
    end
    if (id_wr_en_i && id_dst_i != 0 && cnt_m[id_dst_i] > int'(id_lat_i)) hazard = 1'b1;
    return hazard;
  endfunction

  // Reference select: producers listed youngest first; a producer's age next
  // cycle is its stage number, and only ages up to NUM_STAGES can forward
  function automatic int modelSel(input int s);
    int r = srcOf(s);
    int age_rd [$];
    bit age_wr [$];
    if (!id_src_used_i[s]) return 0;
    age_rd.push_back(int'(ex_rd_i));
    age_wr.push_back(ex_wr_en_i);
    for (int k = 0; k < NUM_STAGES; k++) begin
      age_rd.push_back(int'(st_rd_i[k*REG_AW +: REG_AW]));
      age_wr.push_back(st_wr_en_i[k]);
    end
    for (int a = 0; a < NUM_STAGES; a++) begin
      if (age_wr[a] && age_rd[a] != 0 && age_rd[a] == r) return a + 1;
    end
    return 0;
  endfunction

  task automatic resetModel();
    for (int r = 0; r < NUM_REGS; r++) cnt_m[r] = 0;
    for (int s = 0; s < NUM_SRC; s++) sel_m[s] = 0;
    stall_cnt_m = 0;
  endtask

  // One clock: check the zero-latency stall, advance the model over the
  // edge, then check the registered selects and the stall counter
  task automatic runCycle(input string tag);
    bit stall_e;
    bit issue_e;
    int pred [NUM_SRC];
    #1;
    stall_e = modelStall();
    checkOutput({tag, ":stall"}, 32'(stall_o), 32'(stall_e));
    issue_e = rst_i && id_valid_i && !stall_e && !flush_i;
    for (int s = 0; s < NUM_SRC; s++) pred[s] = issue_e ? modelSel(s) : 0;
    @(posedge clk_i);
    if (rst_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_e && id_wr_en_i && int'(id_dst_i) == r) cnt_m[r] = int'(id_lat_i);
        else if (cnt_m[r] > 0) cnt_m[r] = cnt_m[r] - 1;
      end
      if (stall_e && stall_cnt_m < 64'hFFFF_FFFF) stall_cnt_m++;
      for (int s = 0; s < NUM_SRC; s++) sel_m[s] = pred[s];
    end
    #1;
    for (int s = 0; s < NUM_SRC; s++) begin
      checkOutput($sformatf("%s:sel%0d", tag, s),
                  32'(fwd_sel_o[s*SEL_W +: SEL_W]), 32'(sel_m[s]));
    end
    checkOutput({tag, ":stall_cnt"}, stall_cnt_o, 32'(stall_cnt_m));
  endtask

  // Directed scenarios first, then randomized traffic over a few registers
  initial begin
    resetModel();
    repeat (2) @(posedge clk_i);
    #1;
    applyStimulus(1, 2, 3, 3, 1, 4, 3, 0, 1, 2, 3, 3, 4);
    #1;
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    checkOutput("reset_sel", 32'(fwd_sel_o), 32'd0);
    checkOutput("reset_stall_cnt", stall_cnt_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // ALU producer of r3 in EX forwards from stage 1
    applyStimulus(1, 3, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    runCycle("alu_fwd");
    checkOutput("alu_fwd_sel_const", 32'(fwd_sel_o[SEL_W-1:0]), 32'd1);

    // Load to r5 then an immediate consumer: one bubble, then select 2
    applyStimulus(1, 0, 0, 0, 1, 5, fwd_pkg::LAT_LOAD, 0, 0, 0, 0, 0, 0);
    runCycle("load_issue");
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    runCycle("load_use_stall");
    checkOutput("load_use_cnt_const", stall_cnt_o, 32'd1);
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    runCycle("load_use_issue");
    checkOutput("load_use_sel_const", 32'(fwd_sel_o[SEL_W-1:0]), 32'd2);

    // EX and stage 1 both write r7 on operand 1: EX is youngest
    applyStimulus(1, 0, 7, 2, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    runCycle("youngest");
    checkOutput("youngest_sel_const", 32'(fwd_sel_o[SEL_W +: SEL_W]), 32'd1);

    // Multiply to r4 (3 bubbles) then an ALU write to r4: three WAW stalls
    applyStimulus(1, 0, 0, 0, 1, 4, 3, 0, 0, 0, 0, 0, 0);
    runCycle("mul_issue");
    applyStimulus(1, 0, 0, 0, 1, 4, fwd_pkg::LAT_ALU, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) runCycle($sformatf("waw%0d", i));
    checkOutput("waw_cnt_const", stall_cnt_o, 32'd4);

    // Writes to r0 never forward; an unused operand never forwards
    applyStimulus(1, 0, 6, 1, 0, 0, 0, 0, 1, 0, 1, 6, 0);
    runCycle("r0_and_unused");

    // Multiply to r2 (2 bubbles), consumer stalls, reset lands mid-stall
    applyStimulus(1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0);
    runCycle("r2_issue");
    applyStimulus(1, 2, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    runCycle("r2_stall");
    rst_i = 1'b0;
    #1;
    checkOutput("midrst_stall", 32'(stall_o), 32'd0);
    checkOutput("midrst_sel", 32'(fwd_sel_o), 32'd0);
    checkOutput("midrst_stall_cnt", stall_cnt_o, 32'd0);
    resetModel();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("release_stall_const", 32'(stall_o), 32'd0);
    runCycle("release_issue");

    // Flush during a stall: no stall, no scoreboard write for r9
    applyStimulus(1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0);
    runCycle("flush_prod");
    applyStimulus(1, 2, 0, 1, 1, 9, 3, 1, 1, 2, 0, 0, 0);
    #1;
    checkOutput("flush_stall_const", 32'(stall_o), 32'd0);
    runCycle("flush");
    applyStimulus(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("flush_no_write_const", 32'(stall_o), 32'd0);
    runCycle("after_flush");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(9, 0) < 8) ? 1 : 0,
                    int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                    int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                    int'($urandom_range(7, 0)), int'($urandom_range(MAX_LAT, 0)),
                    ($urandom_range(9, 0) == 0) ? 1 : 0,
                    int'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
                    int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
                    int'($urandom_range(7, 0)));
      runCycle($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised successor to the two-operand MEM/WB forwarding unit. It sits between ID and EX and does two jobs. It computes forwarding selects for NUM_SRC operands across NUM_STAGES post-EX stages, and registers them into EX alongside the ID/EX pipeline register. It also tracks multi-cycle producers (loads, multiplies) in a per-register countdown scoreboard, stalling ID on RAW and WAW hazards that forwarding cannot cover.

## Interface
Parameters:
- REG_AW, 5, register address width (2**REG_AW architectural registers, register 0 hardwired zero)
- NUM_SRC, 2, source operands per instruction
- NUM_STAGES, 2, forwarding stages after EX (1 = MEM, 2 = WB, ...); at least 1
- MAX_LAT, 3, largest bubble count any producer may request
- SEL_W, $clog2(NUM_STAGES+1), forward-select width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- id_valid_i  in  1  valid instruction in ID
- id_src_i  in  NUM_SRC*REG_AW  source register numbers, operand s at [s*REG_AW +: REG_AW]
- id_src_used_i  in  NUM_SRC  operand s is actually read
- id_wr_en_i  in  1  ID instruction writes a register
- id_dst_i  in  REG_AW  ID destination
- id_lat_i  in  $clog2(MAX_LAT+1)  bubbles needed before a consumer may enter EX (ALU 0, load 1)
- flush_i  in  1  kill the ID instruction this cycle
- ex_wr_en_i, ex_rd_i  in  1, REG_AW  producer currently in EX
- st_wr_en_i, st_rd_i  in  NUM_STAGES, NUM_STAGES*REG_AW  producer currently in post-EX stage k (index k-1)
- stall_o  out  1  hold IF/ID, inject bubble into EX
- fwd_sel_o  out  NUM_SRC*SEL_W  registered select for operands now in EX: 0 = register file, k = stage k
- stall_cnt_o  out  32  saturating count of stall cycles

## Operation
- Issue = id_valid_i & ~stall_o & ~flush_i.
- Scoreboard: one counter cnt[r] per register, width $clog2(MAX_LAT+1). On issue with id_wr_en_i and id_dst_i != 0, set cnt[id_dst_i] to id_lat_i. Every other non-zero counter decrements by 1 per cycle. A same-cycle issue write overrides the decrement for that register. cnt[0] is always 0.
- RAW stall: id_valid_i and any s with id_src_used_i[s], id_src != 0 and cnt[id_src] != 0.
- WAW stall: id_valid_i & id_wr_en_i & id_dst_i != 0 & cnt[id_dst_i] > id_lat_i.
- stall_o = (RAW | WAW) & ~flush_i. It is combinational and never asserted while id_valid_i is low.
- Forward select (next-cycle prediction): next cycle the current EX producer sits in stage 1, and the current stage-k producer sits in stage k+1. For each operand s, choose the youngest matching producer: EX first, then stage 1, stage 2, and so on. Only stages up to NUM_STAGES are considered. A producer matches only if wr_en is set, rd != 0 and rd == id_src[s]; else select 0. If id_src_used_i[s] is 0, select 0.
- The fwd_sel register loads the prediction on issue, and loads all-zero on stall, flush or ~id_valid_i (bubble).
- stall_cnt_o increments on each cycle with stall_o high, saturating at 32'hFFFF_FFFF.

## Timing
- Reset (async assert, sync release): all cnt = 0, fwd_sel_o = 0, stall_cnt_o = 0. stall_o = 0 while rst_i is low.
- fwd_sel_o has one-cycle latency: it is valid during the cycle the issued instruction is in EX.
- stall_o has zero latency from the ID inputs and current counters.
- A load (lat 1) followed directly by a consumer gives exactly one stall cycle; the consumer then issues with select 2 when NUM_STAGES >= 2.
- Reset mid-stall clears all counters immediately; the first cycle after release issues without stall.
- flush_i wins over stall and over issue: no scoreboard write, and a bubble goes into fwd_sel.

## Structure
- Package fwd_pkg holds FWD_RF = 0, the helper function sel_w(num_stages), and the latency class constants LAT_ALU = 0, LAT_LOAD = 1.
- Sub-module fwd_scoreboard holds the counter array, set/decrement logic and RAW/WAW lookup. Prediction, select register and stall counter stay in the top.

## Test plan
- ALU producer r3 in EX; consumer reads r3 in ID -> no stall; next cycle fwd_sel_o[op0] = 1.
- Load to r5 (lat 1) issues; consumer of r5 follows -> stall_o = 1 for 1 cycle, stall_cnt_o = 1; consumer issues with select 2.
- EX and stage 1 both write r7; consumer reads r7 -> select 1 (EX producer is youngest).
- Multiply to r4 with lat 3, then ALU write to r4 with lat 0 -> WAW stall for 3 cycles, then issue.
- Producer writes r0, or consumer operand unused -> select 0, no stall.
- cnt[r2] = 2 with reset asserted mid-stall -> after release, stall_o = 0 and fwd_sel_o = 0. Flush during a stall -> stall_o = 0, no counter write.
